regwrite_trace_buffer: RTL and testbench

Synthesizable commit-trace capture block for the RISC-V core.
- Records register-file writebacks and data-memory stores into a first-word-fall-through FIFO.
- Detects EBREAK, stops capture, drains, then flags halted.
- Sits beside the core datapath. Sinks are the SoC debug reader and the simulation bench, which replaces per-test hierarchical register dumping.

---
 rtl/regwrite_trace_buffer_pkg.sv | 17 +
 rtl/regwrite_trace_buffer_if.sv | 13 +
 rtl/regwrite_trace_buffer_fifo.sv | 49 ++++
 rtl/regwrite_trace_buffer.sv | 106 ++++++++++
 tb/tb_regwrite_trace_buffer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/regwrite_trace_buffer_pkg.sv
// trace_pkg: shared types and constants for the commit-trace buffer.
//   EBREAK_INSN   - encoding that stops capture
//   kind_e        - entry kind (register write or store)
//   state_e       - capture FSM states
//   trace_entry_t - one FIFO entry {kind, tag, data, ts}
package trace_pkg;
  localparam int TRACE_XLEN = 32;
  localparam logic [31:0] EBREAK_INSN = 32'h00100073;
  typedef enum logic {KIND_REG = 1'b0, KIND_STORE = 1'b1} kind_e;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
  typedef struct packed {
    kind_e                 kind;
    logic [TRACE_XLEN-1:0] tag;
    logic [TRACE_XLEN-1:0] data;
    logic [31:0]           ts;
  } trace_entry_t;
endpackage

// File: rtl/regwrite_trace_buffer_if.sv
// regwrite_trace_buffer_if: FWFT read port of the trace buffer.
//   master: drives rd_valid/rd_kind/rd_tag/rd_data/rd_ts, samples rd_ready
//   slave : the consumer side of the same signals
interface regwrite_trace_buffer_if #(parameter int XLEN = 32);
  logic            rd_valid;
  logic            rd_ready;
  logic            rd_kind;
  logic [XLEN-1:0] rd_tag;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     rd_ts;
  modport master(output rd_valid, rd_kind, rd_tag, rd_data, rd_ts, input rd_ready);
  modport slave(input rd_valid, rd_kind, rd_tag, rd_data, rd_ts, output rd_ready);
endinterface

// File: rtl/regwrite_trace_buffer_fifo.sv
// trace_fifo_2w1r: dual-push, single-pop first-word-fall-through FIFO.
//   clk, resetn (async, active-low), clear_i (sync flush, beats push/pop)
//   push_n_i: entries written this cycle (0..2), w0_i first, w1_i second
//   pop_i: pop head (ignored when empty); head_o: head entry, 0 when empty
//   level_o: occupancy; free_o: slots available this cycle, counting a pop
module trace_fifo_2w1r import trace_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear_i,
  input  logic [1:0]   push_n_i,
  input  trace_entry_t w0_i,
  input  trace_entry_t w1_i,
  input  logic         pop_i,
  output trace_entry_t head_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] free_o
);
  trace_entry_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  logic pop;
  assign pop = pop_i && level_q != '0;
  assign level_o = level_q;
  assign free_o = LW'(DEPTH) - level_q + LW'(pop);
  assign head_o = level_q != '0 ? mem_q[rp_q] : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else if (clear_i) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push_n_i);
      rp_q <= rp_q + AW'(pop);
      level_q <= level_q + LW'(push_n_i) - LW'(pop);
    end
  // Storage is not reset: head_o is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!clear_i && push_n_i != 2'd0) mem_q[wp_q] <= w0_i;
    if (!clear_i && push_n_i == 2'd2) mem_q[wp_q + AW'(1)] <= w1_i;
  end
endmodule

// File: rtl/regwrite_trace_buffer.sv
// regwrite_trace_buffer: commit-trace capture of register writebacks and stores.
//   clk, resetn (async, active-low), clear_i (sync flush and rearm)
//   wb_*_i: register writeback; st_*_i: data store; instr_*_i: EBREAK detect
//   rd: FWFT read port; level_o occupancy; halted_o EBREAK seen and drained
//   overflow_o sticky drop flag; drop_count_o saturating; event_count_o wrapping
//   Optional macro TRACE_TIMESTAMP_EN stamps entries with a free-running cycle count.
module regwrite_trace_buffer import trace_pkg::*; #(
  parameter int XLEN = TRACE_XLEN,
  parameter int NREG = 32,
  parameter int DEPTH = 16,
  parameter int CW = 16,
  localparam int RW = $clog2(NREG),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            st_valid_i,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  input  logic            clear_i,
  regwrite_trace_buffer_if.master rd,
  output logic [LW-1:0]   level_o,
  output logic            halted_o,
  output logic            overflow_o,
  output logic [CW-1:0]   drop_count_o,
  output logic [31:0]     event_count_o
);
  state_e state_q, state_d;
  logic overflow_q, overflow_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0] event_q, event_d;
  logic [LW-1:0] free;
  logic pop, ebreak, ev_reg, ev_st, drained;
  logic [1:0] n_ev, n_acc, n_drop;
  logic [CW:0] dsum;
  logic [31:0] ts;
  trace_entry_t e_reg, e_st, head;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ts_q <= '0;
    else ts_q <= clear_i ? '0 : ts_q + 32'd1;
  assign ts = ts_q;
`else
  assign ts = '0;
`endif
  always_comb begin
    pop = rd.rd_valid && rd.rd_ready;
    ebreak = instr_valid_i && instr_i == EBREAK_INSN;
    ev_reg = state_q == RUN && wb_valid_i && wb_rd_i != '0;
    ev_st = state_q == RUN && st_valid_i;
    n_ev = {1'b0, ev_reg} + {1'b0, ev_st};
    // Short on space only when free is 0 or 1, so its low bits are the accept count.
    n_acc = free >= LW'(n_ev) ? n_ev : free[1:0];
    n_drop = n_ev - n_acc;
    e_reg = '{kind: KIND_REG, tag: TRACE_XLEN'(wb_rd_i), data: wb_data_i, ts: ts};
    e_st = '{kind: KIND_STORE, tag: st_addr_i, data: st_data_i, ts: ts};
    // Next-cycle level is zero: empty now, or the last entry leaves this cycle.
    drained = level_o == LW'(pop);
    dsum = {1'b0, drop_q} + (CW + 1)'(n_drop);
    state_d = clear_i ? RUN :
              state_q == RUN && ebreak ? DRAIN :
              state_q == DRAIN && drained ? DONE : state_q;
    overflow_d = clear_i ? 1'b0 : overflow_q | (n_drop != 2'd0);
    drop_d = clear_i ? '0 : dsum[CW] ? '1 : dsum[CW-1:0];
    event_d = clear_i ? '0 : event_q + 32'(n_acc);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= RUN;
      overflow_q <= 1'b0;
      drop_q <= '0;
      event_q <= '0;
    end else begin
      state_q <= state_d;
      overflow_q <= overflow_d;
      drop_q <= drop_d;
      event_q <= event_d;
    end
  trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .clear_i(clear_i),
    .push_n_i(n_acc),
    .w0_i(ev_reg ? e_reg : e_st),
    .w1_i(e_st),
    .pop_i(pop),
    .head_o(head),
    .level_o(level_o),
    .free_o(free)
  );
  assign rd.rd_valid = level_o != '0;
  assign rd.rd_kind = head.kind;
  assign rd.rd_tag = head.tag;
  assign rd.rd_data = head.data;
  assign rd.rd_ts = head.ts;
  assign halted_o = state_q == DONE;
  assign overflow_o = overflow_q;
  assign drop_count_o = drop_q;
  assign event_count_o = event_q;
endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// tb_regwrite_trace_buffer: directed scoreboard bench for regwrite_trace_buffer.
module tb_regwrite_trace_buffer;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic wb_valid, st_valid, instr_valid, clear;
  logic [4:0] wb_rd;
  logic [31:0] wb_data, st_addr, st_data, instr;
  logic [4:0] level;
  logic halted, overflow;
  logic [15:0] drop_count;
  logic [31:0] event_count;
  regwrite_trace_buffer_if #(.XLEN(32)) rd_if();
  regwrite_trace_buffer dut (
    .clk(clk), .resetn(resetn),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
    .instr_valid_i(instr_valid), .instr_i(instr), .clear_i(clear),
    .rd(rd_if), .level_o(level), .halted_o(halted), .overflow_o(overflow),
    .drop_count_o(drop_count), .event_count_o(event_count)
  );
  typedef struct {logic [31:0] kind, tag, data, ts;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int m_state = 0, m_drop = 0, m_evt = 0;
  bit m_ovf = 0;
  logic [31:0] cyc;
  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else cyc <= clear ? 0 : cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] kind, tag, data);
    exp_t e;
    e.kind = kind;
    e.tag = tag;
    e.data = data;
`ifdef TRACE_TIMESTAMP_EN
    e.ts = cyc;
`else
    e.ts = 0;
`endif
    return e;
  endfunction
  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    st_valid = 0; st_addr = 0; st_data = 0;
    instr_valid = 0; instr = 0; clear = 0; rd_if.rd_ready = 0;
  endtask
  task automatic chk_state();
    chk("level", 32'(level), 32'(sb.size()));
    chk("halted", 32'(halted), 32'(m_state == 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("event_count", event_count, 32'(m_evt));
  endtask
  task automatic step();
    exp_t ev[$];
    int free;
    bit popv;
    if (sb.size() > 0) begin
      chk("rd_valid", 32'(rd_if.rd_valid), 1);
      chk("rd_kind", 32'(rd_if.rd_kind), sb[0].kind);
      chk("rd_tag", rd_if.rd_tag, sb[0].tag);
      chk("rd_data", rd_if.rd_data, sb[0].data);
      chk("rd_ts", rd_if.rd_ts, sb[0].ts);
    end else chk("rd_valid_empty", 32'(rd_if.rd_valid), 0);
    popv = rd_if.rd_ready && sb.size() > 0;
    if (clear) begin
      sb.delete(); m_ovf = 0; m_drop = 0; m_evt = 0; m_state = 0;
    end else begin
      if (m_state == 0) begin
        if (wb_valid && wb_rd != 0) ev.push_back(mk(0, {27'd0, wb_rd}, wb_data));
        if (st_valid) ev.push_back(mk(1, st_addr, st_data));
      end
      free = 16 - sb.size() + int'(popv);
      if (popv) void'(sb.pop_front());
      foreach (ev[i])
        if (i < free) begin
          sb.push_back(ev[i]); m_evt++;
        end else begin
          m_ovf = 1; if (m_drop < 65535) m_drop++;
        end
      if (m_state == 0 && instr_valid && instr == 32'h00100073) m_state = 1;
      else if (m_state == 1 && sb.size() == 0) m_state = 2;
    end
    @(posedge clk); #1;
    chk_state();
    idle();
  endtask
  task automatic reg_ev(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1; wb_rd = r; wb_data = d;
  endtask
  task automatic st_ev(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1; st_addr = a; st_data = d;
  endtask
  initial begin
    idle();
    #22 resetn = 1;
    #1;
    chk("rst_rd_valid", 32'(rd_if.rd_valid), 0);
    chk("rst_rd_kind", 32'(rd_if.rd_kind), 0);
    chk("rst_rd_tag", rd_if.rd_tag, 0);
    chk("rst_rd_data", rd_if.rd_data, 0);
    chk("rst_rd_ts", rd_if.rd_ts, 0);
    chk_state();
    step(); step();
    reg_ev(5, 32'hDEADBEEF); step();
    reg_ev(0, 32'h1234); step();
    repeat (5) step();
    st_ev(32'h40, 32'h55); step();
    rd_if.rd_ready = 1; step();
    rd_if.rd_ready = 1; step();
    reg_ev(3, 32'h11); st_ev(32'h100, 32'h22); step();
    rd_if.rd_ready = 1; step();
    rd_if.rd_ready = 1; step();
    rd_if.rd_ready = 1; step();
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 2) st_ev(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i));
      else reg_ev(5'(i % 31 + 1), 32'hB0 + 32'(i));
      step();
    end
    reg_ev(2, 32'hC1); step();
    st_ev(32'h2000, 32'hC2); step();
    reg_ev(4, 32'hC3); step();
    rd_if.rd_ready = 1; st_ev(32'h200, 32'h77); step();
    rd_if.rd_ready = 1; reg_ev(9, 32'h99); st_ev(32'h204, 32'h78); step();
    repeat (16) begin rd_if.rd_ready = 1; step(); end
    for (int i = 0; i < 4; i++) begin reg_ev(5'(10 + i), 32'hE0 + 32'(i)); step(); end
    instr_valid = 1; instr = 32'h00100073; reg_ev(7, 32'h77777777); step();
    reg_ev(8, 32'h88); st_ev(32'h300, 32'h33); step();
    repeat (6) begin rd_if.rd_ready = 1; step(); end
    instr_valid = 1; instr = 32'h00100073; reg_ev(6, 32'h66); step();
    clear = 1; reg_ev(4, 32'h44); instr_valid = 1; instr = 32'h00100073; step();
    reg_ev(6, 32'h600D); step();
    st_ev(32'h500, 32'h5A); rd_if.rd_ready = 1; step();
    resetn = 0;
    #1;
    sb.delete(); m_ovf = 0; m_drop = 0; m_evt = 0; m_state = 0;
    chk("midrst_rd_valid", 32'(rd_if.rd_valid), 0);
    chk("midrst_rd_data", rd_if.rd_data, 0);
    chk_state();
    #2 resetn = 1;
    reg_ev(1, 32'h0F0F); step();
    rd_if.rd_ready = 1; step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
